// File: rtl/sdc_sector_server.sv
// Responder for the floppy sector-read handshake: streams 512 bytes of a sector out of a byte-wide memory.
// Optional build macro SDC_START_DELAY_EN inserts a START_LATENCY-cycle WAIT before the first fetch.
module sdc_sector_server #(
  parameter int SECTOR_BITS   = 11,
  parameter int BYTE_GAP      = 2,
  parameter int START_LATENCY = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [3:0]               sdc_rd,
  input  logic [31:0]              sdc_sector,
  output logic                     sdc_busy,
  output logic                     sdc_done,
  output logic                     sdc_byte_in_strobe,
  output logic [8:0]               sdc_byte_in_addr,
  output logic [7:0]               sdc_byte_in_data,
  output logic                     mem_req,
  output logic [SECTOR_BITS+10:0]  mem_addr,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_data,
  output logic [2:0]               state_dbg
);

  // Handshake: a level on any sdc_rd bit is accepted only in IDLE; mem_req stays high with
  // mem_addr stable until mem_ack is seen in the same cycle, and the byte is taken on that edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_GAP    = 3'd3,
    S_STROBE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  state_t                 state, state_n;
  logic [1:0]             drive, pick;
  logic [SECTOR_BITS-1:0] sector_q;
  logic                   oor_q;
  logic [8:0]             offset;
  logic [GW-1:0]          gap_cnt;

`ifdef SDC_START_DELAY_EN
  localparam int WW = (START_LATENCY > 0) ? $clog2(START_LATENCY + 1) : 1;
  logic [WW-1:0]          wait_cnt;
`endif

  always_comb begin
    pick = 2'd0;
    if (sdc_rd[0])      pick = 2'd0;
    else if (sdc_rd[1]) pick = 2'd1;
    else if (sdc_rd[2]) pick = 2'd2;
    else if (sdc_rd[3]) pick = 2'd3;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (|sdc_rd) begin
          state_n = S_FETCH;
`ifdef SDC_START_DELAY_EN
          if (START_LATENCY > 0) state_n = S_WAIT;
`endif
        end
      end
`ifdef SDC_START_DELAY_EN
      S_WAIT:   if (wait_cnt == WW'(START_LATENCY - 1)) state_n = S_FETCH;
`endif
      // Out-of-range sectors skip the memory and return 0x00 at once.
      S_FETCH:  if (oor_q || mem_ack) state_n = S_STROBE;
      S_STROBE: begin
        if (offset == 9'd511)   state_n = S_DONE;
        else if (BYTE_GAP == 0) state_n = S_FETCH;
        else                    state_n = S_GAP;
      end
      S_GAP:    if (gap_cnt == GW'(BYTE_GAP - 1)) state_n = S_FETCH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drive            <= 2'd0;
      sector_q         <= '0;
      oor_q            <= 1'b0;
      offset           <= 9'd0;
      gap_cnt          <= '0;
      sdc_byte_in_addr <= 9'd0;
      sdc_byte_in_data <= 8'd0;
`ifdef SDC_START_DELAY_EN
      wait_cnt         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|sdc_rd) begin
            drive    <= pick;
            sector_q <= sdc_sector[SECTOR_BITS-1:0];
            oor_q    <= |sdc_sector[31:SECTOR_BITS];
            offset   <= 9'd0;
`ifdef SDC_START_DELAY_EN
            wait_cnt <= '0;
`endif
          end
        end
`ifdef SDC_START_DELAY_EN
        S_WAIT: wait_cnt <= wait_cnt + 1'b1;
`endif
        S_FETCH: begin
          if (oor_q) begin
            sdc_byte_in_data <= 8'd0;
            sdc_byte_in_addr <= offset;
          end else if (mem_ack) begin
            sdc_byte_in_data <= mem_data;
            sdc_byte_in_addr <= offset;
          end
        end
        S_STROBE: begin
          if (offset != 9'd511) offset <= offset + 9'd1;
          gap_cnt <= '0;
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign sdc_busy           = (state != S_IDLE);
  assign sdc_done           = (state == S_DONE);
  assign sdc_byte_in_strobe = (state == S_STROBE);
  assign mem_req            = (state == S_FETCH) && !oor_q;
  assign mem_addr           = {drive, sector_q, offset};
  assign state_dbg          = state;

endmodule

// File: tb/tb_sdc_sector_server.sv
// Directed bench for sdc_sector_server: zero-latency pattern memory (data = low address byte),
// a negedge monitor feeding observation queues, and one task per scenario.
module tb_sdc_sector_server;
  localparam int SB = 11;
`ifdef SDC_START_DELAY_EN
  localparam int REQ_LAT = 65;
`else
  localparam int REQ_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3:0]    sdc_rd = 4'd0;
  logic [31:0]   sdc_sector = 32'd0;
  logic          sdc_busy, sdc_done, sdc_byte_in_strobe, mem_req, mem_ack;
  logic [8:0]    sdc_byte_in_addr;
  logic [7:0]    sdc_byte_in_data, mem_data;
  logic [SB+10:0] mem_addr;
  logic [2:0]    state_dbg;
  logic          ack_en = 1'b1;

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  logic [1:0]    exp_drive = 2'd0;
  logic [SB-1:0] exp_sector = '0;

  sdc_sector_server dut (
    .clk(clk), .rstn(rstn), .sdc_rd(sdc_rd), .sdc_sector(sdc_sector),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done), .sdc_byte_in_strobe(sdc_byte_in_strobe),
    .sdc_byte_in_addr(sdc_byte_in_addr), .sdc_byte_in_data(sdc_byte_in_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .state_dbg(state_dbg)
  );

  // Memory answers in the same cycle it is asked.
  assign mem_ack  = mem_req & ack_en;
  assign mem_data = mem_addr[7:0];

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int obs_addr[$], obs_data[$], obs_cyc[$], done_q[$], busy_rise_q[$], busy_fall_q[$], req_rise_q[$];
  int req_cnt = 0, addr_bad = 0, drive3_cnt = 0;
  logic prev_busy = 1'b0, prev_req = 1'b0;
  always @(negedge clk) begin
    if (sdc_byte_in_strobe) begin
      obs_addr.push_back(int'(sdc_byte_in_addr));
      obs_data.push_back(int'(sdc_byte_in_data));
      obs_cyc.push_back(cyc);
    end
    if (sdc_done) done_q.push_back(cyc);
    if (sdc_busy && !prev_busy) busy_rise_q.push_back(cyc);
    if (!sdc_busy && prev_busy) busy_fall_q.push_back(cyc);
    if (mem_req) begin
      req_cnt <= req_cnt + 1;
      if (!prev_req) req_rise_q.push_back(cyc);
      if (mem_addr[SB+10:SB+9] != exp_drive || mem_addr[SB+8:9] != exp_sector) addr_bad <= addr_bad + 1;
      if (mem_addr[SB+10:SB+9] == 2'd3) drive3_cnt <= drive3_cnt + 1;
    end
    prev_busy <= sdc_busy;
    prev_req  <= mem_req;
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_req(input logic [3:0] rd, input logic [31:0] sec,
                           input logic [1:0] drv, input logic [SB-1:0] fld);
    @(negedge clk);
    exp_drive  = drv;
    exp_sector = fld;
    sdc_rd     = rd;
    sdc_sector = sec;
    acc_cyc    = cyc;
    @(negedge clk);
    sdc_rd     = 4'd0;
    sdc_sector = 32'hdead_beef;
  endtask

  task automatic wait_done(input int nd, input int budget);
    int n = 0;
    while (done_q.size() == nd && n < budget) begin
      step();
      n++;
    end
    total++;
    if (done_q.size() == nd) begin
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", budget);
    end
  endtask

  // scoreboard check of one full sector starting at queue index b
  task automatic check_sector(input string name, input int b, input logic zero_data);
    logic [7:0] exp_q[$];
    int n;
    n = obs_addr.size() - b;
    total++;
    if (n !== 512) begin
      bad++;
      $display("FAIL %s_count: got %0d strobes, expected 512", name, n);
    end
    for (int i = 0; i < 512; i++) exp_q.push_back(zero_data ? 8'h00 : 8'(i));
    for (int i = 0; i < 512 && i < n; i++) begin
      total++;
      if (obs_addr[b+i] !== i || obs_data[b+i] !== int'(exp_q[i])) begin
        bad++;
        $display("FAIL %s_byte%0d: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                 name, i, obs_addr[b+i], obs_data[b+i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    step();
    total++;
    if (sdc_busy !== 1'b0 || sdc_done !== 1'b0 || sdc_byte_in_strobe !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b strobe=%b req=%b, expected all 0",
               sdc_busy, sdc_done, sdc_byte_in_strobe, mem_req);
    end
    total++;
    if (mem_addr !== '0 || sdc_byte_in_addr !== 9'd0 || sdc_byte_in_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_data: got mem_addr=%0h addr=%0h data=%0h, expected 0", mem_addr, sdc_byte_in_addr, sdc_byte_in_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int b, nd, nr, nq, bad_snap;
    b = obs_addr.size(); nd = done_q.size(); nr = busy_rise_q.size(); nq = req_rise_q.size();
    bad_snap = addr_bad;
    start_req(4'b0001, 32'd5, 2'd0, SB'(5));
    wait_done(nd, 5000);
    check_sector("basic", b, 1'b0);
    for (int i = 1; i < 512 && b + i < obs_cyc.size(); i++) begin
      total++;
      if (obs_cyc[b+i] - obs_cyc[b+i-1] !== 4) begin
        bad++;
        $display("FAIL basic_spacing%0d: got %0d cycles, expected 4", i, obs_cyc[b+i] - obs_cyc[b+i-1]);
      end
    end
    total++;
    if (busy_rise_q.size() <= nr || busy_rise_q[nr] !== acc_cyc + 1) begin
      bad++;
      $display("FAIL basic_busy_rise: got rise at cycle %0d, expected %0d",
               (busy_rise_q.size() > nr) ? busy_rise_q[nr] : -1, acc_cyc + 1);
    end
    total++;
    if (req_rise_q.size() <= nq || req_rise_q[nq] !== acc_cyc + REQ_LAT) begin
      bad++;
      $display("FAIL basic_first_req: got cycle %0d, expected %0d",
               (req_rise_q.size() > nq) ? req_rise_q[nq] : -1, acc_cyc + REQ_LAT);
    end
    for (int k = 0; k < 4; k++) step();
    total++;
    if (done_q.size() !== nd + 1 || busy_rise_q.size() !== nr + 1 || sdc_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_busy: got dones=%0d rises=%0d busy=%b, expected 1 1 0",
               done_q.size() - nd, busy_rise_q.size() - nr, sdc_busy);
    end
    total++;
    if (done_q.size() > nd && b + 511 < obs_cyc.size() &&
        (done_q[nd] !== obs_cyc[b+511] + 1 || busy_fall_q[busy_fall_q.size()-1] !== done_q[nd] + 1)) begin
      bad++;
      $display("FAIL basic_done_time: got done=%0d fall=%0d, expected %0d %0d", done_q[nd],
               busy_fall_q[busy_fall_q.size()-1], obs_cyc[b+511] + 1, obs_cyc[b+511] + 2);
    end
    total++;
    if (addr_bad !== bad_snap) begin
      bad++;
      $display("FAIL basic_mem_addr: got %0d bad addresses, expected 0", addr_bad - bad_snap);
    end
  endtask

  task automatic test_drive_select();
    int b, nd, rq, bad_snap, d3;
    b = obs_addr.size(); nd = done_q.size(); rq = req_cnt; bad_snap = addr_bad; d3 = drive3_cnt;
    start_req(4'b1010, 32'd3, 2'd1, SB'(3));
    wait_done(nd, 5000);
    check_sector("drive", b, 1'b0);
    total++;
    if (addr_bad !== bad_snap || drive3_cnt !== d3 || req_cnt - rq !== 512) begin
      bad++;
      $display("FAIL drive_fields: got bad_addr=%0d drive3=%0d reqs=%0d, expected 0 0 512",
               addr_bad - bad_snap, drive3_cnt - d3, req_cnt - rq);
    end
  endtask

  task automatic test_out_of_range();
    int b, nd, rq;
    b = obs_addr.size(); nd = done_q.size(); rq = req_cnt;
    start_req(4'b0001, 32'h0001_0000, 2'd0, SB'(0));
    wait_done(nd, 5000);
    check_sector("oor", b, 1'b1);
    total++;
    if (req_cnt !== rq) begin
      bad++;
      $display("FAIL oor_mem_req: got %0d requests, expected 0", req_cnt - rq);
    end
  endtask

  task automatic test_mid_change();
    int b, nd, n, bad_snap, b2;
    b = obs_addr.size(); nd = done_q.size(); bad_snap = addr_bad;
    start_req(4'b0001, 32'd7, 2'd0, SB'(7));
    n = 0;
    while (obs_addr.size() - b < 100 && n < 1000) begin step(); n++; end
    sdc_rd = 4'b0100;
    sdc_sector = 32'd9;
    wait_done(nd, 5000);
    exp_drive = 2'd2;
    exp_sector = SB'(9);
    total++;
    if (addr_bad !== bad_snap) begin
      bad++;
      $display("FAIL mid_addr: got %0d addresses off the original sector, expected 0", addr_bad - bad_snap);
    end
    check_sector("mid", b, 1'b0);
    b2 = obs_addr.size();
    step();
    total++;
    if (sdc_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle_gap: got busy=%b, expected 0", sdc_busy);
    end
    step();
    sdc_rd = 4'd0;
    total++;
    if (sdc_busy !== 1'b1 || mem_addr[SB+10:SB+9] !== 2'd2 || mem_addr[SB+8:9] !== SB'(9)) begin
      bad++;
      $display("FAIL mid_reaccept: got busy=%b drive=%0d sector=%0d, expected 1 2 9",
               sdc_busy, mem_addr[SB+10:SB+9], mem_addr[SB+8:9]);
    end
`ifndef SDC_START_DELAY_EN
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_reaccept_req: got mem_req=%b, expected 1", mem_req);
    end
`endif
    wait_done(nd + 1, 5000);
    check_sector("mid2", b2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int b, nd, n;
    b = obs_addr.size(); nd = done_q.size();
    start_req(4'b0001, 32'd4, 2'd0, SB'(4));
    n = 0;
    while (obs_addr.size() - b < 300 && n < 3000) begin step(); n++; end
    ack_en = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (mem_req !== 1'b1 || mem_addr[8:0] !== 9'd300) begin
      bad++;
      $display("FAIL rst_mid_setup: got req=%b offset=%0d, expected 1 300", mem_req, mem_addr[8:0]);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (sdc_busy !== 1'b0 || sdc_done !== 1'b0 || sdc_byte_in_strobe !== 1'b0 || mem_req !== 1'b0 ||
        mem_addr !== '0 || sdc_byte_in_addr !== 9'd0 || sdc_byte_in_data !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b strobe=%b req=%b maddr=%0h addr=%0h data=%0h, expected all 0",
               sdc_busy, sdc_done, sdc_byte_in_strobe, mem_req, mem_addr, sdc_byte_in_addr, sdc_byte_in_data);
    end
    for (int k = 0; k < 3; k++) step();
    total++;
    if (done_q.size() !== nd) begin
      bad++;
      $display("FAIL rst_mid_no_done: got %0d done pulses, expected 0", done_q.size() - nd);
    end
    @(negedge clk);
    rstn = 1'b1;
    ack_en = 1'b1;
    b = obs_addr.size();
    start_req(4'b0001, 32'd4, 2'd0, SB'(4));
    wait_done(nd, 5000);
    check_sector("rst_restart", b, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drive_select();
    test_out_of_range();
    test_mid_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
